// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_pkg
// Description : Shared constants and result type for the ripple-carry adder.
// Revision    : 1.0
// ============================================================================
package full_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Carry-out concatenated with the sum, at the default width.
    typedef logic [DEFAULT_WIDTH:0] sum_t;

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_if
// Description : Operand/result bundle for full_adder (A, B, Cin in; S, Cout out).
// Revision    : 1.0
// ============================================================================
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output A,
        output B,
        output Cin,
        input  S,
        input  Cout
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output S,
        output Cout
    );
endinterface : full_adder_if
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : One-bit combinational full adder cell.
// Revision    : 1.0
// ============================================================================
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule : full_adder_cell
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : WIDTH-bit ripple-carry adder with optional registered outputs.
// Revision    : 1.0
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    full_adder_if.slave  bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign carry[0] = bus.Cin;
    assign cout_d   = carry[WIDTH];

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_adder_cell u_cell (
                .a_i  (bus.A[i]),
                .b_i  (bus.B[i]),
                .ci_i (carry[i]),
                .s_o  (sum_d[i]),
                .co_o (carry[i+1])
            );
        end
    endgenerate

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] sum_q;
            logic             cout_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                end else begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                end
            end

            assign bus.S    = sum_q;
            assign bus.Cout = cout_q;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign bus.S    = sum_d;
            assign bus.Cout = cout_d;
        end
    endgenerate
endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Directed and random self-checking bench for full_adder.
// Revision    : 1.0
// ============================================================================
module tb_full_adder;
    logic clk;
    logic rst;

    int total;
    int bad;

    full_adder_if #(.WIDTH(1))  if_r1 ();
    full_adder_if #(.WIDTH(1))  if_c1 ();
    full_adder_if #(.WIDTH(4))  if_r4 ();
    full_adder_if #(.WIDTH(8))  if_r8 ();
    full_adder_if #(.WIDTH(16)) if_r16 ();

    full_adder #(.WIDTH(1),  .REG_OUT(1'b1)) u_r1  (.clk(clk), .rst(rst), .bus(if_r1));
    full_adder #(.WIDTH(1),  .REG_OUT(1'b0)) u_c1  (.clk(clk), .rst(rst), .bus(if_c1));
    full_adder #(.WIDTH(4),  .REG_OUT(1'b1)) u_r4  (.clk(clk), .rst(rst), .bus(if_r4));
    full_adder #(.WIDTH(8),  .REG_OUT(1'b1)) u_r8  (.clk(clk), .rst(rst), .bus(if_r8));
    full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_r16 (.clk(clk), .rst(rst), .bus(if_r16));

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {Cout,S} for {A,B,Cin} = 0..7
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        logic [2:0]  v;
        logic [16:0] exp16;
        logic [16:0] prev16;
        logic [1:0]  prev1;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        if_r1.A = '0;  if_r1.B = '0;  if_r1.Cin = 1'b0;
        if_c1.A = '0;  if_c1.B = '0;  if_c1.Cin = 1'b0;
        if_r4.A = '0;  if_r4.B = '0;  if_r4.Cin = 1'b0;
        if_r8.A = '0;  if_r8.B = '0;  if_r8.Cin = 1'b0;
        if_r16.A = '0; if_r16.B = '0; if_r16.Cin = 1'b0;

        // Reset state, before any clock edge
        #5;
        if_r1.A = 1'b1; if_r1.B = 1'b1; if_r1.Cin = 1'b1;
        #1;
        chk("rst_r1",  {15'd0, if_r1.Cout, if_r1.S}, 17'd0);
        chk("rst_r16", {if_r16.Cout, if_r16.S},      17'd0);
        @(posedge clk); #1;
        chk("rst_hold_r1", {15'd0, if_r1.Cout, if_r1.S}, 17'd0);
        if_r1.A = 1'b0; if_r1.B = 1'b0; if_r1.Cin = 1'b0;

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);

        // WIDTH=1 truth table, registered and combinational
        prev1 = 2'b00;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {if_r1.A, if_r1.B, if_r1.Cin} = v;
            {if_c1.A, if_c1.B, if_c1.Cin} = v;
            #1;
            chk($sformatf("comb1_v%0d", i), {15'd0, if_c1.Cout, if_c1.S}, {15'd0, tt[i]});
            chk($sformatf("reg1_hold_v%0d", i), {15'd0, if_r1.Cout, if_r1.S}, {15'd0, prev1});
            @(posedge clk); #1;
            chk($sformatf("reg1_v%0d", i), {15'd0, if_r1.Cout, if_r1.S}, {15'd0, tt[i]});
            prev1 = tt[i];
            @(negedge clk);
        end

        // WIDTH=4 full carry ripple, then alternating bits
        if_r4.A = 4'hF; if_r4.B = 4'h0; if_r4.Cin = 1'b1;
        @(posedge clk); #1;
        chk("w4_ripple", {12'd0, if_r4.Cout, if_r4.S}, {12'd0, 1'b1, 4'h0});
        @(negedge clk);
        if_r4.A = 4'h5; if_r4.B = 4'hA; if_r4.Cin = 1'b0;
        #1;
        chk("w4_hold", {12'd0, if_r4.Cout, if_r4.S}, {12'd0, 1'b1, 4'h0});
        @(posedge clk); #1;
        chk("w4_alt", {12'd0, if_r4.Cout, if_r4.S}, {12'd0, 1'b0, 4'hF});
        @(negedge clk);

        // WIDTH=8 maximum result
        if_r8.A = 8'hFF; if_r8.B = 8'hFF; if_r8.Cin = 1'b1;
        @(posedge clk); #1;
        chk("w8_max", {8'd0, if_r8.Cout, if_r8.S}, {8'd0, 1'b1, 8'hFF});
        @(negedge clk);

        // Reset mid-stream
        if_r1.A = 1'b1; if_r1.B = 1'b1; if_r1.Cin = 1'b1;
        @(posedge clk); #1;
        chk("mid_pre", {15'd0, if_r1.Cout, if_r1.S}, {15'd0, 2'b11});
        #4;
        rst = 1'b1;
        #1;
        chk("mid_async", {15'd0, if_r1.Cout, if_r1.S}, 17'd0);
        chk("mid_async_w8", {8'd0, if_r8.Cout, if_r8.S}, 17'd0);
        @(posedge clk); #1;
        chk("mid_held", {15'd0, if_r1.Cout, if_r1.S}, 17'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_released", {15'd0, if_r1.Cout, if_r1.S}, 17'd0);
        @(posedge clk); #1;
        chk("mid_first_edge", {15'd0, if_r1.Cout, if_r1.S}, {15'd0, 2'b11});
        @(negedge clk);

        // Random WIDTH=16 with one-cycle-delayed expectation
        prev16 = 17'd0;
        for (int n = 0; n < 1000; n++) begin
            if_r16.A   = 16'($urandom);
            if_r16.B   = 16'($urandom);
            if_r16.Cin = 1'($urandom_range(0, 1));
            exp16 = {1'b0, if_r16.A} + {1'b0, if_r16.B} + {16'd0, if_r16.Cin};
            #1;
            chk($sformatf("rnd_hold_%0d", n), {if_r16.Cout, if_r16.S}, prev16);
            @(posedge clk); #1;
            chk($sformatf("rnd_%0d", n), {if_r16.Cout, if_r16.S}, exp16);
            prev16 = exp16;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_full_adder
`default_nettype wire
